img_rsz_pxl_fwd: RTL and testbench
==================================

// Module: img_rsz_pxl_fwd
// PURPOSE
//  Output stage of the image resizer, directly downstream of the block-accumulation stage.
//  - Captures one finished full-colour block-value buffer (FcBlkBuf_t, one entry per resized pixel).
//  - Normalises each entry to a resized pixel: average = sum >> shift; max = saturated pass-through.
//  - Forwards the RSZ_IMG_HEIGHT_SIZE x RSZ_IMG_WIDTH_SIZE pixels serially, in raster order, on a valid/ready stream.
// PARAMETERS
//  ALGORITHM    "AVR-POOLING"  "AVR-POOLING": right-shift by blk_shamt_i; "MAX-POOLING": shift ignored.
//  RSZ_W        8              resized width  (= ImgRszPkg::RSZ_IMG_WIDTH_SIZE).
//  RSZ_H        8              resized height (= ImgRszPkg::RSZ_IMG_HEIGHT_SIZE).
//  COLOR_NUM    1              primaries per pixel (= PXL_PRIM_COLOR_NUM).
//  COLOR_W      8              bits per primary (= PXL_PRIM_COLOR_W).
//  SUM_W        22             block-sum width (= BLK_SUM_MAX_W).
//  SHAMT_MAX    14             largest legal shift (= BLK_MAX_SZ_W).
// PORTS
//  clk          in   1                         single clock; all logic on rising edge.
//  rst_n        in   1                         reset, synchronous, active-low.
//  blk_buf_i    in   FcBlkBuf_t                block values from the accumulation stage.
//  blk_shamt_i  in   ShAmt_t ($clog2(SHAMT_MAX+1))  log2(block pixel count); sampled with blk_buf_i.
//  blk_vld_i    in   1                         blk_buf_i / blk_shamt_i valid.
//  blk_rdy_o    out  1                         stage can capture a new buffer.
//  pxl_data_o   out  FcRszPxlData_t            resized pixel, all primaries.
//  pxl_col_o    out  RSZ_IMG_WIDTH_IDX_W       column index of pxl_data_o.
//  pxl_row_o    out  RSZ_IMG_HEIGHT_IDX_W      row index of pxl_data_o.
//  pxl_last_o   out  1                         set on pixel (RSZ_H-1, RSZ_W-1).
//  pxl_vld_o    out  1                         pixel valid.
//  pxl_rdy_i    in   1                         downstream accepts.
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE.
//   - Outputs: blk_rdy_o=1; pxl_vld_o=0; pxl_last_o=0; row/col=0; pxl_data_o=0.
//   - Internal capture buffer is not reset.
//  FSM states IDLE, FWD.
//   IDLE: blk_rdy_o=1, pxl_vld_o=0.
//    - blk_vld_i=1: capture buffer and shamt, clear row/col, go to FWD.
//    - First pixel is valid the cycle after capture (latency 1).
//   FWD: blk_rdy_o=0, pxl_vld_o=1.
//    - pxl_data_o = norm(buf[c][row][col]) for every colour c.
//    - pxl_vld_o & pxl_rdy_i: col++. At col=RSZ_W-1, col wraps to 0 and row++.
//    - Handshake on the last pixel: go to IDLE, row/col=0. blk_rdy_o returns the next cycle.
//    - No capture is possible in the last-pixel handshake cycle, so there is at least one bubble cycle between frames.
//  Stall rule: while pxl_vld_o=1 and pxl_rdy_i=0, data, row, col and last are held stable.
//   - pxl_vld_o never drops before the handshake completes.
//  pxl_data_o, row, col and last read 0 whenever pxl_vld_o=0.
//  norm(), AVR-POOLING: q = sum >> min(shamt, SHAMT_MAX), truncating.
//   - q > 2^COLOR_W-1 saturates to 2^COLOR_W-1.
//  norm(), MAX-POOLING: q = sum; saturated the same way.
//  blk_vld_i while in FWD is ignored; the upstream holds it until blk_rdy_o.
//  Reset mid-frame: the frame is abandoned, no further pixels are output, and the stage is back in IDLE the next cycle.
// STRUCTURE
//  Add to ImgRszPkg:
//   - ShAmt_t = logic [$clog2(BLK_MAX_SZ_W+1)-1:0]
//   - typedef enum logic {FWD_IDLE, FWD_RUN} PxlFwdState_t
//  Sub-module img_rsz_pxl_norm, combinational, one primary:
//   - in BlkVal_t + ShAmt_t; out RszPxlData_t; param ALGORITHM.
//   - Instantiated COLOR_NUM times via generate.
//  Top: capture register (FcBlkBuf_t), shamt register, FSM, row/col counters, read mux.
// TESTING (default params, COLOR_NUM=1 unless stated)
//  1 Basic: all sums=128<<14, shamt=14, pxl_rdy_i=1.
//    -> 64 pixels of 128, one per cycle, raster order; last on (7,7); blk_rdy_o=1 the cycle after.
//  2 Index/order: sum[r][c]=(r*8+c)<<4, shamt=4.
//    -> pixel k=r*8+c carries k; col wraps 7->0 with row++.
//  3 Backpressure: random pxl_rdy_i (50%).
//    -> data/row/col stable through stalls; exactly 64 handshakes; none lost or duplicated.
//  4 Saturation/clamp: sum=300<<4 with shamt=4 -> 255; shamt=15 -> treated as 14; shamt=0, sum=77 -> 77.
//  5 MAX-POOLING (COLOR_NUM=3): sums {200,1000,5} with shamt=9 -> {200,255,5}; shamt ignored.
//  6 Reset after 10th handshake -> next cycle pxl_vld_o=0, blk_rdy_o=1.
//    New buffer -> restarts at (0,0) with the new data.

Source files
------------

// File: rtl/img_rsz_pkg.sv
// Shared types and default geometry for the image resizer pipeline.
package ImgRszPkg;

    localparam int RSZ_IMG_WIDTH_SIZE  = 8;
    localparam int RSZ_IMG_HEIGHT_SIZE = 8;
    localparam int PXL_PRIM_COLOR_NUM  = 1;
    localparam int PXL_PRIM_COLOR_W    = 8;
    localparam int BLK_SUM_MAX_W       = 22;
    localparam int BLK_MAX_SZ_W        = 14;

    // Index width that stays at least one bit for degenerate single-entry dimensions.
    function automatic int idxW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RSZ_IMG_WIDTH_IDX_W  = idxW(RSZ_IMG_WIDTH_SIZE);
    localparam int RSZ_IMG_HEIGHT_IDX_W = idxW(RSZ_IMG_HEIGHT_SIZE);

    typedef logic [BLK_SUM_MAX_W-1:0]               BlkVal_t;
    typedef logic [PXL_PRIM_COLOR_W-1:0]            RszPxlData_t;
    typedef logic [$clog2(BLK_MAX_SZ_W+1)-1:0]      ShAmt_t;
    typedef BlkVal_t [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0] BlkBuf_t;
    typedef BlkBuf_t [PXL_PRIM_COLOR_NUM-1:0]       FcBlkBuf_t;
    typedef RszPxlData_t [PXL_PRIM_COLOR_NUM-1:0]   FcRszPxlData_t;

    typedef enum logic {FWD_IDLE, FWD_RUN} PxlFwdState_t;

endpackage

// File: rtl/img_rsz_pxl_norm.sv
// Normalises one block sum to a resized primary (average shift or max pass-through, saturated).
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module img_rsz_pxl_norm #(
    parameter string ALGORITHM = "AVR-POOLING",
    parameter int    SUM_W     = 22,
    parameter int    COLOR_W   = 8,
    parameter int    SHAMT_MAX = 14,
    parameter int    SHAMT_W   = 4
) (
    input  logic [SUM_W-1:0]   blkVal,
    input  logic [SHAMT_W-1:0] shAmt,
    output logic [COLOR_W-1:0] pxlData
);

    localparam logic [SUM_W-1:0]   SAT_SUM = SUM_W'((1 << COLOR_W) - 1);
    localparam logic [COLOR_W-1:0] SAT_PXL = '1;

    logic [SHAMT_W-1:0] effShamt;
    logic [SUM_W-1:0]   q;

    always_comb begin
        // Out-of-range shift codes clamp to the largest block size instead of wrapping.
        effShamt = (shAmt > SHAMT_W'(SHAMT_MAX)) ? SHAMT_W'(SHAMT_MAX) : shAmt;
        if (ALGORITHM == "MAX-POOLING") begin
            q = blkVal;
        end else begin
            q = blkVal >> effShamt;
        end
        pxlData = (q > SAT_SUM) ? SAT_PXL : q[COLOR_W-1:0];
    end

endmodule

// File: rtl/img_rsz_pxl_fwd.sv
// Captures a finished block buffer and streams its normalised pixels in raster order.
// Latency: first pixel valid one cycle after capture, then one pixel per accepted cycle.
// Backpressure: pxl_rdy_i low holds the current pixel; blk_rdy_o low for the whole frame.
module img_rsz_pxl_fwd
    import ImgRszPkg::*;
#(
    parameter string ALGORITHM = "AVR-POOLING",
    parameter int    RSZ_W     = RSZ_IMG_WIDTH_SIZE,
    parameter int    RSZ_H     = RSZ_IMG_HEIGHT_SIZE,
    parameter int    COLOR_NUM = PXL_PRIM_COLOR_NUM,
    parameter int    COLOR_W   = PXL_PRIM_COLOR_W,
    parameter int    SUM_W     = BLK_SUM_MAX_W,
    parameter int    SHAMT_MAX = BLK_MAX_SZ_W
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic [COLOR_NUM-1:0][RSZ_H-1:0][RSZ_W-1:0][SUM_W-1:0] blk_buf_i,
    input  logic [$clog2(SHAMT_MAX+1)-1:0]                         blk_shamt_i,
    input  logic                                                   blk_vld_i,
    output logic                                                   blk_rdy_o,
    output logic [COLOR_NUM-1:0][COLOR_W-1:0]                      pxl_data_o,
    output logic [idxW(RSZ_W)-1:0]                                 pxl_col_o,
    output logic [idxW(RSZ_H)-1:0]                                 pxl_row_o,
    output logic                                                   pxl_last_o,
    output logic                                                   pxl_vld_o,
    input  logic                                                   pxl_rdy_i
);

    localparam int COL_W   = idxW(RSZ_W);
    localparam int ROW_W   = idxW(RSZ_H);
    localparam int SHAMT_W = $clog2(SHAMT_MAX + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(RSZ_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(RSZ_H - 1);

    PxlFwdState_t state;
    logic         blkRdy;
    logic         pxlVld;
    logic [ROW_W-1:0] rowIdx;
    logic [COL_W-1:0] colIdx;
    logic         lastPxl;

    logic [COLOR_NUM-1:0][RSZ_H-1:0][RSZ_W-1:0][SUM_W-1:0] capBuf;
    logic [SHAMT_W-1:0]                                    capShamt;
    logic [COLOR_NUM-1:0][COLOR_W-1:0]                     normPxl;

    assign lastPxl = (rowIdx == ROW_LAST) && (colIdx == COL_LAST);

    // Data path has no reset; contents are only observed after a capture.
    always_ff @(posedge clk) begin
        if (state == FWD_IDLE && blk_vld_i) begin
            capBuf   <= blk_buf_i;
            capShamt <= blk_shamt_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= FWD_IDLE;
            blkRdy <= 1'b1;
            pxlVld <= 1'b0;
            rowIdx <= '0;
            colIdx <= '0;
        end else begin
            case (state)
                FWD_IDLE: begin
                    if (blk_vld_i) begin
                        state  <= FWD_RUN;
                        blkRdy <= 1'b0;
                        pxlVld <= 1'b1;
                        rowIdx <= '0;
                        colIdx <= '0;
                    end
                end
                FWD_RUN: begin
                    if (pxl_rdy_i) begin
                        if (lastPxl) begin
                            state  <= FWD_IDLE;
                            blkRdy <= 1'b1;
                            pxlVld <= 1'b0;
                            rowIdx <= '0;
                            colIdx <= '0;
                        end else if (colIdx == COL_LAST) begin
                            colIdx <= '0;
                            rowIdx <= rowIdx + 1'b1;
                        end else begin
                            colIdx <= colIdx + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= FWD_IDLE;
                    blkRdy <= 1'b1;
                    pxlVld <= 1'b0;
                    rowIdx <= '0;
                    colIdx <= '0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < COLOR_NUM; c++) begin : gNorm
        img_rsz_pxl_norm #(
            .ALGORITHM (ALGORITHM),
            .SUM_W     (SUM_W),
            .COLOR_W   (COLOR_W),
            .SHAMT_MAX (SHAMT_MAX),
            .SHAMT_W   (SHAMT_W)
        ) uNorm (
            .blkVal  (capBuf[c][rowIdx][colIdx]),
            .shAmt   (capShamt),
            .pxlData (normPxl[c])
        );
    end

    assign blk_rdy_o  = blkRdy;
    assign pxl_vld_o  = pxlVld;
    assign pxl_row_o  = rowIdx;
    assign pxl_col_o  = colIdx;
    assign pxl_last_o = pxlVld && lastPxl;
    assign pxl_data_o = pxlVld ? normPxl : '0;

endmodule

// File: tb/tb_img_rsz_pxl_fwd.sv
// Randomised bench for the resizer output stage against a frame-level reference model.
module tb_img_rsz_pxl_fwd;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Average-pooling, single primary
    logic [0:0][7:0][7:0][21:0] bufA;
    logic [3:0]                 shA;
    logic                       vldA, blkRdyA, lastA, pxlVldA, rdyA;
    logic [0:0][7:0]            dataA;
    logic [2:0]                 rowA, colA;

    // Max-pooling, three primaries
    logic [2:0][7:0][7:0][21:0] bufM;
    logic [3:0]                 shM;
    logic                       vldM, blkRdyM, lastM, pxlVldM, rdyM;
    logic [2:0][7:0]            dataM;
    logic [2:0]                 rowM, colM;

    img_rsz_pxl_fwd dutA (
        .clk(clk), .rst_n(rst_n),
        .blk_buf_i(bufA), .blk_shamt_i(shA), .blk_vld_i(vldA), .blk_rdy_o(blkRdyA),
        .pxl_data_o(dataA), .pxl_col_o(colA), .pxl_row_o(rowA), .pxl_last_o(lastA),
        .pxl_vld_o(pxlVldA), .pxl_rdy_i(rdyA)
    );

    img_rsz_pxl_fwd #(.ALGORITHM("MAX-POOLING"), .COLOR_NUM(3)) dutM (
        .clk(clk), .rst_n(rst_n),
        .blk_buf_i(bufM), .blk_shamt_i(shM), .blk_vld_i(vldM), .blk_rdy_o(blkRdyM),
        .pxl_data_o(dataM), .pxl_col_o(colM), .pxl_row_o(rowM), .pxl_last_o(lastM),
        .pxl_vld_o(pxlVldM), .pxl_rdy_i(rdyM)
    );

    int nChk  = 0;
    int nFail = 0;
    int sumA [8][8];
    int shamtA;
    int sumM [3][8][8];

    task automatic check(input string tag, input longint obs, input longint exp);
        nChk++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference normalisation straight from the arithmetic definition.
    function automatic longint refNorm(input longint sum, input int sh, input bit isMax);
        longint q;
        int s;
        s = (sh > 14) ? 14 : sh;
        q = isMax ? sum : (sum >> s);
        return (q > 255) ? 255 : q;
    endfunction

    task automatic checkIdle(input string tag);
        check({tag, ".vld"},    pxlVldA, 0);
        check({tag, ".blkRdy"}, blkRdyA, 1);
        check({tag, ".row"},    rowA,    0);
        check({tag, ".col"},    colA,    0);
        check({tag, ".last"},   lastA,   0);
        check({tag, ".data"},   dataA,   0);
    endtask

    // Sends sumA/shamtA into dutA and checks handshakes until stopAfter pixels have left.
    task automatic frameA(input int rdyPct, input int stopAfter, input bit holdVld);
        int got, cyc, r, c;
        bit stalled;
        logic [7:0] hData;
        logic [2:0] hRow, hCol;
        logic hLast;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                bufA[0][i][j] = 22'(sumA[i][j]);
        shA = 4'(shamtA);
        check("blkRdyBeforeCapture", blkRdyA, 1);
        vldA = 1'b1;
        @(negedge clk);
        if (holdVld) begin
            // Upstream keeps offering a different buffer; it must not disturb the frame.
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    bufA[0][i][j] = 22'($urandom);
            shA = 4'($urandom_range(0, 15));
        end else begin
            vldA = 1'b0;
        end
        check("blkRdyInFwd", blkRdyA, 0);
        got = 0; cyc = 0; stalled = 1'b0;
        hData = '0; hRow = '0; hCol = '0; hLast = 1'b0;
        while (got < stopAfter && cyc < 4000) begin
            cyc++;
            check("vldUntilHandshake", pxlVldA, 1);
            if (stalled) begin
                check("stallData", dataA, hData);
                check("stallRow",  rowA,  hRow);
                check("stallCol",  colA,  hCol);
                check("stallLast", lastA, hLast);
            end
            rdyA = ($urandom_range(0, 99) < rdyPct);
            if (rdyA) begin
                r = got / 8;
                c = got % 8;
                check("row",  rowA,  r);
                check("col",  colA,  c);
                check("data", dataA, refNorm(sumA[r][c], shamtA, 1'b0));
                check("last", lastA, (got == 63) ? 1 : 0);
                check("blkRdyBusy", blkRdyA, 0);
                if (holdVld && got == 63) vldA = 1'b0;
                got++;
            end
            stalled = !rdyA;
            hData = dataA; hRow = rowA; hCol = colA; hLast = lastA;
            @(negedge clk);
        end
        check("handshakeCount", got, stopAfter);
        if (stopAfter == 64) begin
            rdyA = 1'b0;
            checkIdle("afterFrame");
            rdyA = 1'b1;
            @(negedge clk);
            check("noExtraPixel", pxlVldA, 0);
            rdyA = 1'b0;
        end
    endtask

    task automatic frameM();
        longint expd;
        int r, c;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    bufM[k][i][j] = 22'(sumM[k][i][j]);
        shM  = 4'd9;
        vldM = 1'b1;
        rdyM = 1'b1;
        @(negedge clk);
        vldM = 1'b0;
        for (int k = 0; k < 64; k++) begin
            r = k / 8;
            c = k % 8;
            expd = 0;
            for (int p = 0; p < 3; p++)
                expd = expd | (refNorm(sumM[p][r][c], 9, 1'b1) << (8 * p));
            check("maxVld",  pxlVldM, 1);
            check("maxRow",  rowM,    r);
            check("maxCol",  colM,    c);
            check("maxData", dataM,   expd);
            check("maxLast", lastM,   (k == 63) ? 1 : 0);
            @(negedge clk);
        end
        check("maxDone",   pxlVldM, 0);
        check("maxBlkRdy", blkRdyM, 1);
        rdyM = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        vldA = 1'b0; rdyA = 1'b0; bufA = '0; shA = '0;
        vldM = 1'b0; rdyM = 1'b0; bufM = '0; shM = '0;
        repeat (3) @(negedge clk);
        checkIdle("reset");
        check("resetM.vld",    pxlVldM, 0);
        check("resetM.blkRdy", blkRdyM, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Uniform buffer, full throughput
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) sumA[i][j] = 128 << 14;
        shamtA = 14;
        frameA(100, 64, 1'b0);

        // Index pattern exposes ordering and wrap
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) sumA[i][j] = (i * 8 + j) << 4;
        shamtA = 4;
        frameA(100, 64, 1'b1);

        // Random data under random backpressure
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) sumA[i][j] = int'($urandom & 32'h3F_FFFF);
            shamtA = $urandom_range(0, 15);
            frameA(50, 64, 1'b0);
        end

        // Saturation and shift clamping corners
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) sumA[i][j] = $urandom_range(0, 8191);
        sumA[0][0] = 300 << 4;
        shamtA = 4;
        frameA(70, 64, 1'b0);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) sumA[i][j] = int'($urandom & 32'h3F_FFFF);
        sumA[0][0] = 200 << 14;
        shamtA = 15;
        frameA(70, 64, 1'b0);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) sumA[i][j] = $urandom_range(0, 511);
        sumA[0][0] = 77;
        shamtA = 0;
        frameA(70, 64, 1'b0);

        // Max pooling, three primaries, shift ignored
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    sumM[k][i][j] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 400) : int'($urandom & 32'h3F_FFFF);
        sumM[0][0][0] = 200;
        sumM[1][0][0] = 1000;
        sumM[2][0][0] = 5;
        frameM();

        // Reset mid-frame after the tenth handshake
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) sumA[i][j] = int'($urandom & 32'h3F_FFFF);
        shamtA = 6;
        frameA(100, 10, 1'b0);
        rdyA  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checkIdle("midFrameReset");
        rst_n = 1'b1;
        @(negedge clk);
        check("resetNoResume", pxlVldA, 0);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) sumA[i][j] = ((i * 8 + j) * 3 + 1) << 2;
        shamtA = 2;
        frameA(60, 64, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
